// File: rtl/prime_pair_pkg.sv
// Shared types and default sizes for the prime-pair sequencer.
package prime_pair_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEEK_P = 3'd1,
    SEEK_Q = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_BITS    = 128;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/prime_pair_wdog.sv
// Search watchdog: reloadable down-counter that flags expiry while enabled.
// TIMEOUT_CYC=0 removes the counter and holds expire low.
module prime_pair_wdog
  import prime_pair_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

      logic [CW-1:0] count_reg;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          count_reg <= LOAD;
        end else if (clr) begin
          count_reg <= LOAD;
        end else if (en && (count_reg != '0)) begin
          count_reg <= count_reg - CW'(1);
        end
      end

      assign expire = en && (count_reg == '0);
    end
  endgenerate

endmodule

// File: rtl/prime_pair_ctrl.sv
// Collects two distinct primes from the tester and presents them as a held (p, q) pair.
// Optional PRIME_PAIR_ORDER_EN orders the pair so that key_p > key_q.
module prime_pair_ctrl
  import prime_pair_pkg::*;
#(
  parameter int unsigned NUM_BITS    = DEF_NUM_BITS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                lfsr_en,
  input  logic [NUM_BITS-1:0] prime_in,
  input  logic                prime_valid,
  output logic                prime_ready,
  output logic [NUM_BITS-1:0] key_p,
  output logic [NUM_BITS-1:0] key_q,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                busy,
  output logic                timeout,
  output logic [CNT_W-1:0]    dup_cnt
);

  state_t              state_reg, state_next;
  logic [NUM_BITS-1:0] key_p_reg, key_p_next;
  logic [NUM_BITS-1:0] key_q_reg, key_q_next;
  logic [CNT_W-1:0]    dup_cnt_reg, dup_cnt_next;
  logic                lfsr_en_reg, lfsr_en_next;
  logic                prime_ready_reg, prime_ready_next;
  logic                key_valid_reg, key_valid_next;
  logic                busy_reg, busy_next;
  logic                timeout_reg, timeout_next;

  logic xfer, seek, dup, wd_clr, wd_expire;

  assign xfer   = prime_valid & prime_ready_reg;
  assign seek   = (state_reg == SEEK_P) || (state_reg == SEEK_Q);
  assign dup    = (prime_in == key_p_reg);
  // Watchdog restarts on every entry to a search and after every accepted prime.
  assign wd_clr = !seek || xfer;

  prime_pair_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (wd_clr),
    .en      (seek),
    .expire  (wd_expire)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg       <= IDLE;
      key_p_reg       <= '0;
      key_q_reg       <= '0;
      dup_cnt_reg     <= '0;
      lfsr_en_reg     <= 1'b0;
      prime_ready_reg <= 1'b0;
      key_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      key_p_reg       <= key_p_next;
      key_q_reg       <= key_q_next;
      dup_cnt_reg     <= dup_cnt_next;
      lfsr_en_reg     <= lfsr_en_next;
      prime_ready_reg <= prime_ready_next;
      key_valid_reg   <= key_valid_next;
      busy_reg        <= busy_next;
      timeout_reg     <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    key_p_next   = key_p_reg;
    key_q_next   = key_q_reg;
    dup_cnt_next = dup_cnt_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      IDLE: begin
        dup_cnt_next = '0;
        if (start) state_next = SEEK_P;
      end
      SEEK_P: begin
        // An accepted prime on the expiry cycle takes priority over the abort.
        if (xfer) begin
          key_p_next = prime_in;
          state_next = SEEK_Q;
        end else if (wd_expire) begin
          state_next = ERR;
        end
      end
      SEEK_Q: begin
        if (xfer) begin
          if (dup) begin
            if (dup_cnt_reg != '1) dup_cnt_next = dup_cnt_reg + CNT_W'(1);
          end else begin
`ifdef PRIME_PAIR_ORDER_EN
            if (prime_in > key_p_reg) begin
              key_p_next = prime_in;
              key_q_next = key_p_reg;
            end else begin
              key_q_next = prime_in;
            end
`else
            key_q_next = prime_in;
`endif
            state_next = HOLD;
          end
        end else if (wd_expire) begin
          state_next = ERR;
        end
      end
      HOLD: begin
        if (key_ready) state_next = start ? SEEK_P : IDLE;
      end
      ERR: begin
        if (start) begin
          state_next   = SEEK_P;
          timeout_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // A half-built pair is dropped when the search aborts.
    if ((state_next == ERR) && (state_reg != ERR)) begin
      key_p_next   = '0;
      timeout_next = 1'b1;
    end
    if ((state_next == SEEK_P) && (state_reg != SEEK_P)) dup_cnt_next = '0;

    lfsr_en_next     = (state_next == SEEK_P) || (state_next == SEEK_Q);
    prime_ready_next = (state_next == SEEK_P) || (state_next == SEEK_Q);
    key_valid_next   = (state_next == HOLD);
    busy_next        = (state_next != IDLE);
  end

  assign lfsr_en     = lfsr_en_reg;
  assign prime_ready = prime_ready_reg;
  assign key_p       = key_p_reg;
  assign key_q       = key_q_reg;
  assign key_valid   = key_valid_reg;
  assign busy        = busy_reg;
  assign timeout     = timeout_reg;
  assign dup_cnt     = dup_cnt_reg;

endmodule

// File: doc/prime_pair_ctrl.md
Name: prime_pair_ctrl

Overview:
- Sequencer for the key-material path: random generator -> candidate FIFO -> primality tester -> this block.
- Gates the generator and accepts two distinct primes from the tester's output over a valid/ready handshake.
- Presents them as a registered (p, q) pair to the downstream key-assembly logic.
- A watchdog aborts a search that stalls.

Parameters:
- NUM_BITS, 128: width of each prime and of key_p/key_q.
- TIMEOUT_CYC, 1000000: cycles allowed without an accepted prime before abort; 0 disables the watchdog.
- CNT_W, 8: width of dup_cnt.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  synchronous active-low reset.
- start  in  1  level request to begin or retry a pair search; sampled in IDLE and ERR.
- lfsr_en  out  1  enable to the random generator.
- prime_in  in  NUM_BITS  prime from the primality tester.
- prime_valid  in  1  prime_in valid.
- prime_ready  out  1  block accepts prime_in this cycle.
- key_p  out  NUM_BITS  first prime of the pair.
- key_q  out  NUM_BITS  second prime of the pair.
- key_valid  out  1  key_p/key_q valid.
- key_ready  in  1  downstream consumes the pair.
- busy  out  1  state is not IDLE.
- timeout  out  1  sticky abort flag.
- dup_cnt  out  CNT_W  duplicates rejected in the current search, saturating.

Behaviour:
- Clock and reset: one clock, aclk. Reset is synchronous, active-low (aresetn). Every flop is reset.
- Reset values: state=IDLE; lfsr_en, prime_ready, key_valid, busy, timeout = 0; key_p, key_q, dup_cnt = 0.
- States:
  - IDLE, SEEK_P, SEEK_Q, HOLD, ERR.
  - Outputs are registered; they reflect the state one cycle after the transition.
- IDLE:
  - start=1 -> SEEK_P.
  - Clear dup_cnt and the watchdog.
- SEEK_P:
  - lfsr_en=1, prime_ready=1.
  - A transfer is prime_valid & prime_ready on the same edge.
  - On transfer: key_p <= prime_in; watchdog cleared; -> SEEK_Q.
- SEEK_Q:
  - lfsr_en=1, prime_ready=1.
  - If transfer and prime_in == key_p: discard, dup_cnt += 1 (saturates at all-ones), watchdog cleared, stay.
  - If transfer and prime_in != key_p: key_q <= prime_in; -> HOLD.
- HOLD:
  - lfsr_en=0, prime_ready=0, key_valid=1.
  - key_p/key_q stay stable while key_valid=1 and key_ready=0.
  - key_valid & key_ready: if start=1, go directly to SEEK_P (back-to-back pairs; dup_cnt cleared); else -> IDLE.
- Watchdog:
  - Counts cycles in SEEK_P/SEEK_Q since entry or last transfer.
  - When it reaches TIMEOUT_CYC-1 with no transfer in that cycle -> ERR.
  - A transfer in the same cycle wins over the timeout.
- ERR:
  - timeout=1, lfsr_en=0, prime_ready=0.
  - Any partially captured key_p is discarded.
  - start=1 -> SEEK_P; timeout cleared on that transition.
- Never accepted: prime_valid in IDLE, HOLD or ERR is not accepted (prime_ready=0); the tester holds its output.
- Latency:
  - start to lfsr_en=1: 1 cycle.
  - Second transfer to key_valid=1: 1 cycle.
  - key_ready handshake to key_valid=0: 1 cycle.
- Reset mid-operation: aresetn=0 in any state returns to IDLE next edge; the pending pair is dropped.
- busy=1 in all states except IDLE.

Optional Feature:
- Macro: PRIME_PAIR_ORDER_EN.
- Defined:
  - When q is captured, the pair is ordered so that key_p > key_q (unsigned). If prime_in > stored p, swap on capture.
  - Adds one NUM_BITS comparator and a mux; latency unchanged.
- Undefined: key_p is always the first accepted prime, key_q the second.

Decomposition:
- Package prime_pair_pkg:
  - state enum (IDLE=0, SEEK_P=1, SEEK_Q=2, HOLD=3, ERR=4, 3-bit).
  - Default NUM_BITS and TIMEOUT_CYC constants.
- One sub-module, prime_pair_wdog:
  - Loadable down-counter with clear, enable and expire outputs.
  - Parameter TIMEOUT_CYC; counter width $clog2(TIMEOUT_CYC+1).
  - Tied inactive when TIMEOUT_CYC=0.

Test Plan:
- Basic pair: reset, start=1 one cycle, tester delivers 0x...0B then 0x...0D.
  - Required: key_valid=1 one cycle after the second transfer; key_p=0x0B, key_q=0x0D; lfsr_en=0 in HOLD.
- Duplicate: deliver 0x11, 0x11, 0x11, 0x13.
  - Required: dup_cnt=2; key_q=0x13; state remains SEEK_Q across the duplicates.
- Backpressure/back-to-back: key_ready=0 for 20 cycles, then 1 with start=1.
  - Required: key_p/key_q stable for those 20 cycles; next state SEEK_P; dup_cnt=0.
- Timeout: TIMEOUT_CYC=16, start, no prime_valid.
  - Required: ERR with timeout=1 after 16 cycles; lfsr_en=0.
  - Then start -> SEEK_P and timeout=0.
  - Repeat with prime_valid arriving on the expiry cycle -> transfer accepted, no ERR.
- Reset mid-search: aresetn=0 during SEEK_Q after p=0x17.
  - Required: next edge all outputs at reset values; key_p=0.
- PRIME_PAIR_ORDER_EN defined: deliver 0x05 then 0x1D.
  - Required: key_p=0x1D, key_q=0x05.
  - Without the macro: key_p=0x05, key_q=0x1D.
